// File: rtl/ray_memory_responder.sv
`default_nettype none
// ============================================================================
// ray_memory_responder : MemoryBus slave with a word array, a two-stage read pipe
// and a credit-checked response FIFO. Optional macro: RAY_MEMORY_RANGE_CHECK_EN
// Revision 1.0
// ============================================================================
module ray_memory_responder #(
  parameter int                     DATA_WIDTH    = 24,
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     ID_WIDTH      = 4,
  parameter int                     DEPTH         = 4096,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int                     FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic                     reqWrite,
  input  logic [ADDRESS_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0]    reqData,
  input  logic [ID_WIDTH-1:0]      reqId,
  output logic                     respValid,
  input  logic                     respReady,
  output logic                     respWrite,
  output logic [DATA_WIDTH-1:0]    respData,
  output logic [ID_WIDTH-1:0]      respId,
  output logic                     respError
);
  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_sum_w = $clog2(FIFO_DEPTH + 3);
  localparam int c_ent_w = 2 + ID_WIDTH + DATA_WIDTH;

  logic [c_idx_w-1:0] req_idx;
  logic               req_err;
`ifdef RAY_MEMORY_RANGE_CHECK_EN
  logic [ADDRESS_WIDTH:0] req_offset;
  always_comb begin
    // Extra MSB catches addresses below BASE_ADDRESS as a borrow.
    req_offset = {1'b0, reqAddress} - {1'b0, BASE_ADDRESS};
    req_idx    = req_offset[c_idx_w-1:0];
    req_err    = req_offset[ADDRESS_WIDTH] ||
                 (req_offset[ADDRESS_WIDTH-1:0] >= ADDRESS_WIDTH'(DEPTH));
  end
`else
  always_comb begin
    req_idx = c_idx_w'(reqAddress - BASE_ADDRESS);
    req_err = 1'b0;
  end
`endif

  logic                  s1_valid_q, s1_valid_d, s1_write_q, s1_write_d, s1_err_q, s1_err_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
  logic [c_idx_w-1:0]    s1_idx_q, s1_idx_d;
  logic                  s2_valid_q, s2_valid_d, s2_write_q, s2_write_d, s2_err_q, s2_err_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]    count_q, count_d;
  logic                  req_ready_q, req_ready_d;
  logic                  accept, push, pop, mem_we;
  logic [c_sum_w-1:0]    credit_sum;
  logic [DATA_WIDTH-1:0] rdata_q, push_data;
  logic [c_ent_w-1:0]    head;

  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic [c_ent_w-1:0]    fifo_q [FIFO_DEPTH];

  always_comb begin
    accept      = reqValid && req_ready_q;
    push        = s2_valid_q;
    pop         = (count_q != '0) && respReady;
    mem_we      = accept && reqWrite && !req_err;
    s1_valid_d  = accept;
    s1_write_d  = reqWrite;
    s1_err_d    = req_err;
    s1_id_d     = reqId;
    s1_idx_d    = req_idx;
    s2_valid_d  = s1_valid_q;
    s2_write_d  = s1_write_q;
    s2_err_d    = s1_err_q;
    s2_id_d     = s1_id_q;
    push_data   = (s2_write_q || s2_err_q) ? '0 : rdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + c_ptr_w'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + c_ptr_w'(1);
    count_d     = count_q + c_cnt_w'(push) - c_cnt_w'(pop);
    // Ready is precomputed from next-state so it is a flop yet tracks credits exactly.
    credit_sum  = c_sum_w'(count_d) + c_sum_w'(s1_valid_d) + c_sum_w'(s2_valid_d);
    req_ready_d = credit_sum < c_sum_w'(FIFO_DEPTH);
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[req_idx] <= reqData;
    rdata_q <= mem_q[s1_idx_q];
    if (push) fifo_q[wr_ptr_q] <= {s2_write_q, s2_err_q, s2_id_q, push_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_write_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_id_q     <= '0;
      s1_idx_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_write_q  <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_id_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_write_q  <= s1_write_d;
      s1_err_q    <= s1_err_d;
      s1_id_q     <= s1_id_d;
      s1_idx_q    <= s1_idx_d;
      s2_valid_q  <= s2_valid_d;
      s2_write_q  <= s2_write_d;
      s2_err_q    <= s2_err_d;
      s2_id_q     <= s2_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Outputs are gated by respValid so stale FIFO contents never leak out.
  assign head      = fifo_q[rd_ptr_q];
  assign reqReady  = req_ready_q;
  assign respValid = (count_q != '0);
  assign respWrite = respValid && head[c_ent_w-1];
  assign respError = respValid && head[c_ent_w-2];
  assign respId    = respValid ? head[DATA_WIDTH +: ID_WIDTH] : '0;
  assign respData  = respValid ? head[DATA_WIDTH-1:0] : '0;
endmodule
`default_nettype wire
